// File: rtl/fe_pkg.sv
// Shared GF(2^255 - 19) constants and helpers used by the field adder, subtractor and multiplier.
// Elements are N words of W bits, least-significant word first.
package fe_pkg;

    localparam int unsigned W    = 17;
    localparam int unsigned N    = 15;
    localparam int unsigned C    = 19;
    localparam int unsigned LOGN = 4;
    localparam int unsigned EW   = W * N;

    localparam logic [EW-1:0] P = {EW{1'b1}} - EW'(C - 1);

    typedef struct packed {
        logic [EW-1:0] a;
        logic [EW-1:0] b;
    } fe_pair_t;

    // Word i of P: only the lowest word differs from all-ones.
    function automatic logic [W-1:0] p_word(input logic [LOGN-1:0] i);
        if (i == '0) begin
            return W'((2 ** W) - C);
        end
        return {W{1'b1}};
    endfunction

endpackage

// File: rtl/feadd_if.sv
// Start/done handshake and operand/result bus shared by the word-serial field units.
interface feadd_if;
    import fe_pkg::*;

    logic          start;
    logic [EW-1:0] a_in;
    logic [EW-1:0] b_in;
    logic          busy;
    logic          done;
    logic [EW-1:0] out;

    modport master (output start, a_in, b_in, input busy, done, out);
    modport slave  (input start, a_in, b_in, output busy, done, out);

endinterface

// File: rtl/fe_word_addsub.sv
// One W-bit word of a + b (with carry) and of that sum minus the matching P word (with borrow).
module fe_word_addsub
    import fe_pkg::*;
(
    input  logic [W-1:0] a_w,
    input  logic [W-1:0] b_w,
    input  logic [W-1:0] p_w,
    input  logic         carry_in,
    input  logic         borrow_in,
    output logic [W-1:0] s_w,
    output logic         carry_out,
    output logic [W-1:0] t_w,
    output logic         borrow_out
);

    logic [W:0] s_full;
    logic [W:0] t_full;

    always_comb begin
        s_full     = {1'b0, a_w} + {1'b0, b_w} + (W+1)'(carry_in);
        t_full     = {1'b0, s_full[W-1:0]} - {1'b0, p_w} - (W+1)'(borrow_in);
        s_w        = s_full[W-1:0];
        carry_out  = s_full[W];
        t_w        = t_full[W-1:0];
        borrow_out = t_full[W];
    end

endmodule

// File: rtl/feadd.sv
// Word-serial modular adder: out = (a + b) mod P, one W-bit word per clock, start/done handshake.
// Sum and sum-minus-P are built in parallel; the final carry/borrow picks the canonical one.
module feadd
    import fe_pkg::*;
(
    input  logic    clock,
    input  logic    reset_n,
    feadd_if.slave  bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]      state_q,  state_d;
    logic [LOGN-1:0] idx_q,    idx_d;
    fe_pair_t        op_q,     op_d;
    logic [EW-1:0]   sum_q,    sum_d;
    logic [EW-1:0]   diff_q,   diff_d;
    logic [EW-1:0]   out_q,    out_d;
    logic            carry_q,  carry_d;
    logic            borrow_q, borrow_d;
    logic            sel_q,    sel_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;

    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;
    logic         w_carry;
    logic         w_borrow;

    fe_word_addsub u_word (
        .a_w        (op_q.a[W-1:0]),
        .b_w        (op_q.b[W-1:0]),
        .p_w        (p_word(idx_q)),
        .carry_in   (carry_q),
        .borrow_in  (borrow_q),
        .s_w        (w_sum),
        .carry_out  (w_carry),
        .t_w        (w_diff),
        .borrow_out (w_borrow)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        sum_d    = sum_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = '{a: bus.a_in, b: bus.b_in};
                    idx_d    = '0;
                    carry_d  = 1'b0;
                    borrow_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                op_d.a   = op_q.a >> W;
                op_d.b   = op_q.b >> W;
                sum_d    = {w_sum,  sum_q[EW-1:W]};
                diff_d   = {w_diff, diff_q[EW-1:W]};
                carry_d  = w_carry;
                borrow_d = w_borrow;
                idx_d    = idx_q + LOGN'(1);
                if (idx_q == LOGN'(N - 1)) begin
                    // No final borrow, or a carry out of bit 254, means a + b >= P.
                    sel_d   = w_carry | ~w_borrow;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = LOGN'(N);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = LOGN'(N);
                busy_d  = 1'b0;
            end
        endcase

        out_d = sel_d ? diff_d : sum_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= LOGN'(N);
            op_q     <= '0;
            sum_q    <= '0;
            diff_q   <= '0;
            out_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            sum_q    <= sum_d;
            diff_q   <= diff_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;

endmodule

// File: tb/tb_feadd.sv
// Scoreboard bench for feadd: driver queues expected (a + b) mod P and done cycle, monitor checks on done.
module tb_feadd;

    localparam int unsigned EWID = 255;
    localparam int          NRAND = 2000;

    typedef struct {
        logic [EWID-1:0] val;
        int              cyc;
    } exp_t;

    logic clock;
    logic reset_n;
    int   cyc;
    int   tests;
    int   fails;
    exp_t exp_q[$];
    logic [255:0] pmod;

    feadd_if bus_i ();

    feadd dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [EWID-1:0] act, input logic [EWID-1:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [EWID-1:0] ref_add(input logic [EWID-1:0] a, input logic [EWID-1:0] b);
        logic [255:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= pmod) s = s - pmod;
        return s[EWID-1:0];
    endfunction

    function automatic logic [EWID-1:0] rand_fe();
        logic [255:0] r;
        int mode;
        mode = int'($urandom_range(0, 5));
        if (mode == 0) begin
            r = pmod - 256'(1) - 256'($urandom_range(0, 40));
        end else if (mode == 1) begin
            r = 256'($urandom_range(0, 300000));
        end else begin
            do begin
                for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
                r[255] = 1'b0;
            end while (r >= pmod);
        end
        return r[EWID-1:0];
    endfunction

    // Monitor: every done must match the oldest expectation in value and cycle, with busy low.
    always @(negedge clock) begin
        if (reset_n && bus_i.done) begin
            if (exp_q.size() == 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL unexpected_done: done at cycle %0d with out %h", cyc, bus_i.out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", bus_i.out, e.val);
                chk("done_cycle", EWID'(cyc), EWID'(e.cyc));
                chk("busy_in_done", EWID'(bus_i.busy), EWID'(0));
            end
        end
    end

    // Issue one operation at a negedge and wait out its full run.
    task automatic issue(input logic [EWID-1:0] a, input logic [EWID-1:0] b);
        exp_t e;
        @(negedge clock);
        bus_i.start = 1'b1;
        bus_i.a_in  = a;
        bus_i.b_in  = b;
        e.val = ref_add(a, b);
        e.cyc = cyc + 16;
        exp_q.push_back(e);
        @(negedge clock);
        bus_i.start = 1'b0;
        bus_i.a_in  = '0;
        bus_i.b_in  = '0;
        chk("busy_after_start", EWID'(bus_i.busy), EWID'(1));
        repeat (15) @(negedge clock);
    endtask

    initial begin
        logic [EWID-1:0] a;
        logic [EWID-1:0] b;
        exp_t e;

        cyc   = 0;
        tests = 0;
        fails = 0;
        pmod  = (256'(1) << 255) - 256'(19);
        bus_i.start = 1'b0;
        bus_i.a_in  = '0;
        bus_i.b_in  = '0;
        reset_n     = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_busy", EWID'(bus_i.busy), EWID'(0));
        chk("reset_done", EWID'(bus_i.done), EWID'(0));
        chk("reset_out",  bus_i.out, '0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed corner cases.
        issue(EWID'(1), EWID'(2));
        issue(EWID'(17'h1FFFF), EWID'(1));
        issue(pmod[EWID-1:0] - EWID'(1), EWID'(1));
        a = EWID'(1) << 254;
        issue(a, a - EWID'(19));
        issue(pmod[EWID-1:0] - EWID'(1), pmod[EWID-1:0] - EWID'(1));
        chk("p_minus_2_direct", ref_add(pmod[EWID-1:0] - EWID'(1), pmod[EWID-1:0] - EWID'(1)),
            pmod[EWID-1:0] - EWID'(2));

        // Start pulses during RUN must be ignored.
        @(negedge clock);
        bus_i.start = 1'b1;
        bus_i.a_in  = EWID'(1000);
        bus_i.b_in  = EWID'(2345);
        e.val = ref_add(EWID'(1000), EWID'(2345));
        e.cyc = cyc + 16;
        exp_q.push_back(e);
        @(negedge clock);
        bus_i.start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 3 || k == 10) begin
                bus_i.start = 1'b1;
                bus_i.a_in  = rand_fe();
                bus_i.b_in  = rand_fe();
            end else begin
                bus_i.start = 1'b0;
            end
            @(negedge clock);
        end
        bus_i.start = 1'b0;
        repeat (2) @(negedge clock);

        // Start held high: back-to-back operations every 16 clocks.
        bus_i.start = 1'b1;
        bus_i.a_in  = EWID'(5);
        bus_i.b_in  = EWID'(7);
        for (int k = 1; k <= 3; k++) begin
            e.val = EWID'(12);
            e.cyc = cyc + 16 * k;
            exp_q.push_back(e);
        end
        repeat (48) @(negedge clock);
        bus_i.start = 1'b0;
        repeat (2) @(negedge clock);

        // Asynchronous reset mid-run aborts without a done.
        bus_i.start = 1'b1;
        bus_i.a_in  = EWID'(77);
        bus_i.b_in  = EWID'(88);
        @(negedge clock);
        bus_i.start = 1'b0;
        repeat (6) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", EWID'(bus_i.busy), EWID'(0));
        chk("abort_done", EWID'(bus_i.done), EWID'(0));
        chk("abort_out",  bus_i.out, '0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        issue(EWID'(123456789), EWID'(987654321));

        // Randomized canonical pairs.
        for (int n = 0; n < NRAND; n++) begin
            a = rand_fe();
            b = rand_fe();
            issue(a, b);
        end

        repeat (4) @(negedge clock);
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL missing_done: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
